// File: rtl/mixcol_sequencer.sv
// mixcol_sequencer: column-serial AES MixColumns engine.
// Accepts a 128-bit state in IDLE and mixes COLS_PER_CYCLE columns per BUSY
// cycle through a shared GF(2^8) column-mix unit. It then holds the result in
// DONE until the downstream side takes it. When the final-round flag is set,
// the state passes through unchanged with the same timing.
module mixcol_sequencer #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_final,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int N    = COLS_PER_CYCLE;
  // Guard against a division by zero so that only the $error below reports a bad N.
  localparam int NGRP = (N == 1 || N == 2 || N == 4) ? (4 / N) : 1;
  localparam logic [1:0] LAST_GRP = 2'(NGRP - 1);

  if (!(N == 1 || N == 2 || N == 4)) begin : g_bad_cols_per_cycle
    $error("mixcol_sequencer: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [1:0]   grp_q, grp_d;
  logic         fin_q, fin_d;

  // GF(2^8) multiply by 2 using the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column. Row 0 is the most significant byte of the column.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Each lane picks column grp*N+lane out of the work register. Column c sits at
  // bits [127-32c -: 32], so its LSB offset is (3-c)*32, which is {~c, 5'b0}.
  logic [6:0]  lane_base [N];
  logic [31:0] lane_mix  [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [1:0] col_idx;
    assign col_idx       = 2'(int'(grp_q) * N + gi);
    assign lane_base[gi] = {~col_idx, 5'd0};
    assign lane_mix[gi]  = mix_col(work_q[{~col_idx, 5'd0} +: 32]);
  end

  // State, work register, group counter and final flag; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= 128'h0;
      grp_q   <= 2'd0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      grp_q   <= grp_d;
      fin_q   <= fin_d;
    end
  end

  // Next-state logic: accept in IDLE, mix one group per BUSY cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    grp_d   = grp_q;
    fin_d   = fin_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          fin_d   = in_final;
          grp_d   = 2'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!fin_q) begin
          for (int k = 0; k < N; k++) begin
            work_d[lane_base[k] +: 32] = lane_mix[k];
          end
        end
        grp_d = grp_q + 2'd1;
        if (grp_q == LAST_GRP) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state register or taken from the work register.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY) || (state_q == S_DONE);
  assign out_state = work_q;

endmodule

// File: tb/tb_mixcol_sequencer.sv
// Testbench for mixcol_sequencer: scoreboard plus monitor, randomized states checked
// against a GF(2^8) matrix-multiply reference model.
module tb_mixcol_sequencer;

  localparam int LAT = 5;  // accept-to-out_valid latency for one column per cycle
  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] BYP_IN   = 128'hd4d4d4d5_c6c6c6c6_00112233_8899aabb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_final;
  logic [127:0] in_state;
  logic         out_valid, out_ready, busy;
  logic [127:0] out_state;

  // Second stimulus set shared by the two- and four-column instances.
  logic         x_valid, x_final, x_oready;
  logic [127:0] x_state;
  logic         x_ready2, x_ovalid2, x_busy2;
  logic         x_ready4, x_ovalid4, x_busy4;
  logic [127:0] x_out2, x_out4;

  always #5 clk = ~clk;

  mixcol_sequencer #(.COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_final(in_final), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  mixcol_sequencer #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ready2),
    .in_state(x_state), .in_final(x_final), .out_valid(x_ovalid2),
    .out_ready(x_oready), .out_state(x_out2), .busy(x_busy2)
  );

  mixcol_sequencer #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_ready4),
    .in_state(x_state), .in_final(x_final), .out_valid(x_ovalid4),
    .out_ready(x_oready), .out_state(x_out4), .busy(x_busy4)
  );

  typedef struct {
    logic [127:0] st;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference model: generic shift-and-add GF(2^8) multiply and the MixColumns matrix.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic fin);
    logic [7:0]   m [4][4];
    logic [127:0] r;
    logic [7:0]   acc;
    m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
          '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
    r = s;
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        for (int row = 0; row < 4; row++) begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc ^= gmul(m[row][k], s[127 - 32*c - 8*k -: 8]);
          r[127 - 32*c - 8*row -: 8] = acc;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [127:0] st);
    exp_t e;
    e.st  = st;
    e.acc = cyc;
    sbq.push_back(e);
  endtask

  // Offer one block, wait (bounded) for acceptance, record the expected result.
  task automatic send(input logic [127:0] st, input logic fin, input logic [127:0] req);
    int g;
    tick();
    in_state = st;
    in_final = fin;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));
    if (in_ready) push_exp(req);
    tick();
    in_valid = 1'b0;
    in_final = 1'b0;
    in_state = rand128();
  endtask

  task automatic drain();
    for (int g = 0; g < 100 && sbq.size() != 0; g++) tick();
    chk("drain_empty", 128'(sbq.size()), 128'(0));
  endtask

  // Monitor: latency on each rising out_valid, data on each output handshake,
  // and the return to IDLE one cycle after a handshake.
  initial begin : monitor
    logic prev_ov;
    logic prev_hs;
    exp_t e;
    prev_ov = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) begin
          chk("post_hs_out_valid", 128'(out_valid), 128'(0));
          chk("post_hs_in_ready", 128'(in_ready), 128'(1));
        end
        if (out_valid && !prev_ov) begin
          chk("pending_block", 128'(sbq.size() != 0), 128'(1));
          if (sbq.size() != 0) chk("latency", 128'(cyc - sbq[0].acc), 128'(LAT));
        end
        prev_hs = out_valid && out_ready;
        if (prev_hs && sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("out_data", out_state, e.st);
          $display("txn: acc_cycle=%0d out_cycle=%0d out_state=%h", e.acc, cyc, out_state);
        end
        prev_ov = out_valid && !out_ready;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [127:0] a_st, a_exp;
    int           sent, last_acc, lat2, lat4, g;
    logic         seen2, seen4;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_final = 1'b0;
    in_state = 128'h0;
    out_ready = 1'b1;
    x_valid  = 1'b0;
    x_final  = 1'b0;
    x_state  = 128'h0;
    x_oready = 1'b1;
    repeat (3) tick();
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_out_state", out_state, 128'h0);
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;

    // FIPS vector through the two- and four-column instances in parallel.
    tick();
    x_valid = 1'b1;
    x_state = FIPS_IN;
    chk("x2_in_ready", 128'(x_ready2), 128'(1));
    chk("x4_in_ready", 128'(x_ready4), 128'(1));
    tick();
    x_valid = 1'b0;
    seen2 = 1'b0;
    seen4 = 1'b0;
    lat2  = -1;
    lat4  = -1;
    for (int c = 1; c <= 8; c++) begin
      if (x_ovalid2 && !seen2) begin
        seen2 = 1'b1;
        lat2  = c;
        chk("x2_data", x_out2, FIPS_OUT);
      end
      if (x_ovalid4 && !seen4) begin
        seen4 = 1'b1;
        lat4  = c;
        chk("x4_data", x_out4, FIPS_OUT);
      end
      tick();
    end
    chk("x2_latency", 128'(lat2), 128'(3));
    chk("x4_latency", 128'(lat4), 128'(2));

    // FIPS vector, one column per cycle.
    send(FIPS_IN, 1'b0, FIPS_OUT);
    drain();

    // Bypass, then the same state mixed normally.
    send(BYP_IN, 1'b1, BYP_IN);
    drain();
    send(BYP_IN, 1'b0, ref_mix(BYP_IN, 1'b0));
    drain();
    chk("byp_col0", 128'(out_state[127:96]), 128'(32'hd5d5d7d6));
    chk("byp_col1", 128'(out_state[95:64]), 128'(32'hc6c6c6c6));

    // Backpressure: 10 cycles in DONE with a competing in_valid.
    a_st  = rand128();
    a_exp = ref_mix(a_st, 1'b0);
    out_ready = 1'b0;
    send(a_st, 1'b0, a_exp);
    g = 0;
    while (!out_valid && g < 20) begin
      tick();
      g++;
    end
    chk("bp_reach_done", 128'(out_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      in_valid = 1'b1;
      in_state = ~a_st;
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_state", out_state, a_exp);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 128'(in_ready), 128'(1));
    drain();

    // Back-to-back: in_valid and out_ready held high, 8 random blocks.
    tick();
    in_valid = 1'b1;
    in_state = rand128();
    in_final = ($urandom_range(3) == 0);
    sent     = 0;
    last_acc = 0;
    for (int i = 0; i < 200 && sent < 8; i++) begin
      if (in_ready) begin
        push_exp(ref_mix(in_state, in_final));
        if (sent > 0) chk("b2b_period", 128'(cyc - last_acc), 128'(6));
        last_acc = cyc;
        sent++;
        tick();
        in_state = rand128();
        in_final = ($urandom_range(3) == 0);
      end else begin
        tick();
      end
    end
    chk("b2b_sent", 128'(sent), 128'(8));
    in_valid = 1'b0;
    in_final = 1'b0;
    drain();

    // Reset in the middle of BUSY discards the block.
    send(rand128(), 1'b0, 128'h0);
    tick();
    rst_n = 1'b0;
    sbq.delete();
    repeat (3) tick();
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_out_state", out_state, 128'h0);
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;
    repeat (12) tick();
    chk("midrst_quiet", 128'(out_valid), 128'(0));

    // Normal operation after the reset.
    a_st = rand128();
    send(a_st, 1'b0, ref_mix(a_st, 1'b0));
    drain();

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
